// File: rtl/hs.sv
// hs: registered bit-sliced half subtractor.
// Each of the WIDTH slices computes diff = a ^ b and borrow = ~a & b on its own.
// No borrow ripples between slices. One valid-qualified pipeline register stage.
// Optional feature macro: HS_STATS_EN adds stat_clr and a saturating borrow event counter, borrow_cnt.
module hs #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic             borrow_any
`ifdef HS_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] borrow_cnt
`endif
);

  // Reject nonsensical configurations at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("hs: WIDTH must be >= 1");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("hs: CNT_W must be >= 1");
  end

  logic [WIDTH-1:0] slice_diff;
  logic [WIDTH-1:0] slice_borrow;
  logic             slice_any;

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic [WIDTH-1:0] borrow_d, borrow_q;
  logic             borrow_any_d, borrow_any_q;

  // Per-slice half subtractor on the raw port values.
  always_comb begin
    slice_diff   = a ^ b;
    slice_borrow = ~a & b;
    slice_any    = |slice_borrow;
  end

  // Capture a new result only when in_valid is high, so idle-cycle a/b (even X) never reach the registers.
  always_comb begin
    valid_d      = in_valid;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_any_d = borrow_any_q;
    if (in_valid) begin
      diff_d       = slice_diff;
      borrow_d     = slice_borrow;
      borrow_any_d = slice_any;
    end
  end

  // Result register; reset clears everything, which discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      diff_q       <= '0;
      borrow_q     <= '0;
      borrow_any_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_any_q <= borrow_any_d;
    end
  end

  assign out_valid  = valid_q;
  assign diff       = diff_q;
  assign borrow     = borrow_q;
  assign borrow_any = borrow_any_q;

`ifdef HS_STATS_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count accepted inputs that produce any borrow; saturate at all-ones and let a clear override an increment.
  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (in_valid && slice_any && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Borrow event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_hs.sv
// tb_hs: randomized self-checking bench for hs.
// It drives a WIDTH=8 instance with CNT_W=2 and a WIDTH=1 instance side by side from one clock and reset.
// The stat_clr and borrow_cnt checks are present only when HS_STATS_EN is defined.
module tb_hs;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       out_valid8, borrow_any8;
  logic [7:0] diff8, borrow8;
  logic       out_valid1, borrow_any1;
  logic [0:0] diff1, borrow1;
`ifdef HS_STATS_EN
  logic             stat_clr;
  logic [CNT_W-1:0] borrow_cnt8;
  logic [15:0]      borrow_cnt1;
`endif

  int check_count;
  int pass_count;

  // Reference model state: what the outputs must show after the most recent edge.
  logic       m_valid;
  logic [7:0] m_diff8, m_borrow8;
  logic       m_any8;
  logic       m_diff1, m_borrow1, m_any1;
  int         m_cnt;

  hs #(.WIDTH(8), .CNT_W(CNT_W)) u_hs8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a8),
    .b          (b8),
    .out_valid  (out_valid8),
    .diff       (diff8),
    .borrow     (borrow8),
    .borrow_any (borrow_any8)
`ifdef HS_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .borrow_cnt (borrow_cnt8)
`endif
  );

  hs #(.WIDTH(1)) u_hs1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .a          (a1),
    .b          (b1),
    .out_valid  (out_valid1),
    .diff       (diff1),
    .borrow     (borrow1),
    .borrow_any (borrow_any1)
`ifdef HS_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .borrow_cnt (borrow_cnt1)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value differs from the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Model: per bit, difference is (a-b) mod 2 and borrow occurs when the minuend bit is smaller.
  function automatic logic [7:0] refDiff(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = ((int'(x[i]) - int'(y[i]) + 2) % 2) == 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] refBorrow(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = int'(x[i]) < int'(y[i]);
    end
    return r;
  endfunction

  task automatic modelReset();
    m_valid   = 1'b0;
    m_diff8   = '0;
    m_borrow8 = '0;
    m_any8    = 1'b0;
    m_diff1   = 1'b0;
    m_borrow1 = 1'b0;
    m_any1    = 1'b0;
    m_cnt     = 0;
  endtask

  task automatic compareAll(input string phase);
    checkOutput({phase, ".valid8"},  32'(out_valid8),  32'(m_valid));
    checkOutput({phase, ".diff8"},   32'(diff8),       32'(m_diff8));
    checkOutput({phase, ".borrow8"}, 32'(borrow8),     32'(m_borrow8));
    checkOutput({phase, ".any8"},    32'(borrow_any8), 32'(m_any8));
    checkOutput({phase, ".valid1"},  32'(out_valid1),  32'(m_valid));
    checkOutput({phase, ".diff1"},   32'(diff1),       32'(m_diff1));
    checkOutput({phase, ".borrow1"}, 32'(borrow1),     32'(m_borrow1));
    checkOutput({phase, ".any1"},    32'(borrow_any1), 32'(m_any1));
`ifdef HS_STATS_EN
    checkOutput({phase, ".cnt8"},    32'(borrow_cnt8), 32'(m_cnt));
`endif
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge, and check at the next falling edge.
  task automatic applyStimulus(input string phase, input logic v, input logic [7:0] av, input logic [7:0] bv,
                               input logic a1v, input logic b1v, input logic clr);
    logic [7:0] rb;
    in_valid = v;
    if (v) begin
      a8 = av;
      b8 = bv;
      a1 = a1v;
      b1 = b1v;
    end else begin
      a8 = 'x;
      b8 = 'x;
      a1 = 'x;
      b1 = 'x;
    end
`ifdef HS_STATS_EN
    stat_clr = clr;
`endif
    @(posedge clk);
    m_valid = v;
    if (v) begin
      rb        = refBorrow(av, bv);
      m_diff8   = refDiff(av, bv);
      m_borrow8 = rb;
      m_any8    = rb != 8'h00;
      m_diff1   = refDiff({7'b0, a1v}, {7'b0, b1v}) != 8'h00;
      m_borrow1 = refBorrow({7'b0, a1v}, {7'b0, b1v}) != 8'h00;
      m_any1    = m_borrow1;
    end else begin
      rb = 8'h00;
    end
    if (clr) begin
      m_cnt = 0;
    end else if (v && rb != 8'h00 && m_cnt < CNT_MAX) begin
      m_cnt = m_cnt + 1;
    end
    @(negedge clk);
    compareAll(phase);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic [1:0] ab;
    check_count = 0;
    pass_count  = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a8 = '0;
    b8 = '0;
    a1 = '0;
    b1 = '0;
`ifdef HS_STATS_EN
    stat_clr = 1'b0;
`endif
    modelReset();
    #2;
    compareAll("reset");
    @(negedge clk);
    @(negedge clk);
    compareAll("reset_hold");
    rst_n = 1'b1;

    // Directed patterns: the 8-bit example, and a full truth-table sweep of the 1-bit slice.
    applyStimulus("f0_3c", 1'b1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("f0_3c.diff_const",   32'(diff8),   32'h0000_00CC);
    checkOutput("f0_3c.borrow_const", 32'(borrow8), 32'h0000_000C);
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      applyStimulus("sweep", 1'b1, 8'(i * 37), 8'(i * 91), ab[1], ab[0], 1'b0);
    end

    // A single valid pulse followed by idle cycles: valid drops and the captured data holds.
    applyStimulus("pulse", 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus("idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    end

    // Equal operands give no difference and no borrow, and the counter does not move.
    applyStimulus("ones",  1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    applyStimulus("zeros", 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

    // Clear the counter, then send five borrowing inputs so the 2-bit counter saturates.
    applyStimulus("clr", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus("sat", 1'b1, 8'h10, 8'h31 + 8'(i), 1'b0, 1'b1, 1'b0);
    end
`ifdef HS_STATS_EN
    checkOutput("sat.cnt_const", 32'(borrow_cnt8), 32'd3);
`endif
    applyStimulus("clr_wins", 1'b1, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
`ifdef HS_STATS_EN
    checkOutput("clr_wins.cnt_const", 32'(borrow_cnt8), 32'd0);
`endif

    // Randomized traffic with occasional idle cycles and clears.
    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus("rand", ($urandom_range(0, 3) != 0), ra, rb, ra[0], rb[0], ($urandom_range(0, 15) == 0));
    end

    // Reset in the middle of a cycle with a valid input pending: outputs drop at once and stay low.
    applyStimulus("pre_rst", 1'b1, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    a8 = 8'h00;
    b8 = 8'hFF;
    a1 = 1'b0;
    b1 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    compareAll("async_rst");
    @(posedge clk);
    @(negedge clk);
    compareAll("rst_held");
    rst_n = 1'b1;
    applyStimulus("post_rst_idle", 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus("post_rst_valid", 1'b1, 8'h33, 8'h55, 1'b1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
